// File: rtl/ov5640_init_pkg.sv
// Shared types and table-word field positions for the OV5640 init sequencer.
package ov5640_init_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PWR_WAIT,
    S_FETCH,
    S_LATCH,
    S_WRITE,
    S_RST_WAIT,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [15:0] SOFT_RESET_REG = 16'h3008;
  localparam int          REG_ADDR_MSB   = 23;
  localparam int          REG_ADDR_LSB   = 8;
  localparam int          DATA_MSB       = 7;

  // A write to 0x3008 with bit 7 set resets the sensor and needs a settle wait.
  function automatic logic is_soft_reset(input logic [15:0] reg_addr, input logic [7:0] data);
    return (reg_addr == SOFT_RESET_REG) && data[DATA_MSB];
  endfunction

endpackage

// File: rtl/ov5640_init_sequencer_delay.sv
// Down-counter shared by the power-up and soft-reset waits.
// zero_o is high during the last of N enabled wait cycles after loading N.
module init_delay_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [23:0] load_val_i,
  input  logic        en_i,
  output logic        zero_o
);

  logic [23:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != 24'd0)) begin
      cnt_q <= cnt_q - 24'd1;
    end
  end

  assign zero_o = (cnt_q <= 24'd1);

endmodule

// File: rtl/ov5640_init_sequencer.sv
// Walks the OV5640 init table and issues one SCCB register write per entry,
// with power-up and soft-reset waits, retry-on-NACK and sticky done/error flags.
module ov5640_init_sequencer
  import ov5640_init_pkg::*;
#(
  parameter int          DATA_WIDTH     = 24,
  parameter int          ADDR_WIDTH     = 8,
  parameter int          TABLE_LEN      = 86,
  parameter logic [23:0] POWERUP_CYCLES = 24'd1_000_000,
  parameter logic [23:0] RESET_CYCLES   = 24'd250_000,
  parameter int          MAX_RETRY      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic                  sccb_req,
  output logic [15:0]           sccb_reg_addr,
  output logic [7:0]            sccb_wr_data,
  input  logic                  sccb_ack,
  input  logic                  sccb_err,
  output logic                  busy,
  output logic                  init_done,
  output logic                  init_err
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX    = ADDR_WIDTH'(TABLE_LEN - 1);
  localparam logic [1:0]            MAX_RETRY_L = 2'(MAX_RETRY);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [1:0]              retry_q;
  logic                    sccb_req_q;
  logic [15:0]             reg_addr_q;
  logic [7:0]              wr_data_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;

  logic                    idle_like;
  logic                    start_load;
  logic                    soft_rst;
  logic                    ok_ack;
  logic                    rst_load;
  logic                    advance_d;
  logic                    dly_zero;
  logic [23:0]             dly_val;

  assign idle_like  = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
  assign start_load = idle_like && start;
  assign soft_rst   = is_soft_reset(reg_addr_q, wr_data_q);
  assign ok_ack     = (state_q == S_WRITE) && sccb_ack && !sccb_err;
  assign rst_load   = ok_ack && soft_rst && (RESET_CYCLES != 24'd0);
  // Both a plain successful write and the end of a reset settle move to the next entry.
  assign advance_d  = (ok_ack && !rst_load) || ((state_q == S_RST_WAIT) && dly_zero);
  assign dly_val    = start_load ? POWERUP_CYCLES : RESET_CYCLES;

  init_delay_counter u_delay (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (start_load || rst_load),
    .load_val_i (dly_val),
    .en_i       ((state_q == S_PWR_WAIT) || (state_q == S_RST_WAIT)),
    .zero_o     (dly_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      retry_q    <= '0;
      sccb_req_q <= 1'b0;
      reg_addr_q <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            retry_q <= '0;
            state_q <= (POWERUP_CYCLES == 24'd0) ? S_FETCH : S_PWR_WAIT;
          end
        end
        S_PWR_WAIT: begin
          if (dly_zero) state_q <= S_FETCH;
        end
        S_FETCH: state_q <= S_LATCH;
        S_LATCH: begin
          reg_addr_q <= rom_q[REG_ADDR_MSB:REG_ADDR_LSB];
          wr_data_q  <= rom_q[DATA_MSB:0];
          sccb_req_q <= 1'b1;
          state_q    <= S_WRITE;
        end
        S_WRITE: begin
          if (sccb_ack) begin
            sccb_req_q <= 1'b0;
            if (sccb_err) begin
              if (retry_q < MAX_RETRY_L) begin
                retry_q <= retry_q + 2'd1;
                state_q <= S_FETCH;
              end else begin
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_ERROR;
              end
            end else if (rst_load) begin
              state_q <= S_RST_WAIT;
            end
          end
        end
        S_RST_WAIT: ;
        default: state_q <= S_IDLE;
      endcase

      // Terminal check precedes the increment, so the index never wraps.
      if (advance_d) begin
        if (idx_q == LAST_IDX) begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end else begin
          idx_q   <= idx_q + ADDR_WIDTH'(1);
          retry_q <= '0;
          state_q <= S_FETCH;
        end
      end
    end
  end

  assign rom_addr      = idx_q;
  assign sccb_req      = sccb_req_q;
  assign sccb_reg_addr = reg_addr_q;
  assign sccb_wr_data  = wr_data_q;
  assign busy          = busy_q;
  assign init_done     = done_q;
  assign init_err      = err_q;

endmodule

// File: tb/tb_ov5640_init_sequencer.sv
// Scoreboard bench: a table-level model queues the expected SCCB writes per run,
// a negedge monitor answers requests and checks each one against the queue.
module tb_ov5640_init_sequencer;

  localparam int          TLEN  = 4;
  localparam int          POW   = 10;
  localparam int          RST   = 5;
  localparam int          MAXR  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [23:0] rom_q = 24'h0;
  logic        sccb_req;
  logic [15:0] sccb_reg_addr;
  logic [7:0]  sccb_wr_data;
  logic        sccb_ack = 1'b0;
  logic        sccb_err = 1'b0;
  logic        busy, init_done, init_err;

  ov5640_init_sequencer #(
    .DATA_WIDTH(24), .ADDR_WIDTH(8), .TABLE_LEN(TLEN),
    .POWERUP_CYCLES(24'd10), .RESET_CYCLES(24'd5), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr), .rom_q(rom_q),
    .sccb_req(sccb_req), .sccb_reg_addr(sccb_reg_addr), .sccb_wr_data(sccb_wr_data),
    .sccb_ack(sccb_ack), .sccb_err(sccb_err), .busy(busy),
    .init_done(init_done), .init_err(init_err)
  );

  always #5 clk = ~clk;

  logic [23:0] rom [TLEN] = '{24'h300882, 24'h310303, 24'h3017ff, 24'h3018ff};
  always @(posedge clk) rom_q <= (rom_addr < 8'(TLEN)) ? rom[rom_addr[1:0]] : 24'h0;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          idx;
    logic [15:0] addr;
    logic [7:0]  data;
    int          gap;      // posedges from start/ack sample to request rising
    int          hold;     // cycles the responder keeps the request waiting
    bit          err;
    int          outcome;  // 0 continue, 1 done, 2 abort
  } req_t;

  req_t exp_q[$];
  req_t cur;
  int   vectors = 0;
  int   miscompares = 0;
  int   last_ref = 0;
  bit   mon_en = 1'b0;
  bit   run_end = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Reference model: expected write sequence for one run given NACK counts per entry.
  task automatic build_run(input int errs[TLEN], input int hold_entry);
    req_t r;
    int   gap = POW + 2;
    for (int e = 0; e < TLEN; e++) begin
      for (int a = 0; a <= errs[e] && a <= MAXR; a++) begin
        r.idx  = e;
        r.addr = rom[e][23:8];
        r.data = rom[e][7:0];
        r.gap  = gap;
        r.hold = (e == hold_entry) ? 7 : int'($urandom_range(0, 4));
        r.err  = (a < errs[e]);
        if (r.err) begin
          r.outcome = (a == MAXR) ? 2 : 0;
          gap = 2;
        end else begin
          r.outcome = (e == TLEN - 1) ? 1 : 0;
          gap = (r.addr == 16'h3008 && r.data[7]) ? RST + 2 : 2;
        end
        exp_q.push_back(r);
        if (r.outcome == 2) return;
      end
    end
  endtask

  // Monitor / SCCB responder
  initial begin
    bit post_ack = 1'b0;
    bit in_write = 1'b0;
    bit req_prev = 1'b0;
    int hold = 0;
    forever begin
      @(negedge clk);
      sccb_ack = 1'b0;
      sccb_err = 1'($urandom);
      if (!mon_en) begin
        post_ack = 1'b0; in_write = 1'b0; req_prev = 1'b0;
        continue;
      end
      if (post_ack) begin
        post_ack = 1'b0;
        chk("req_drop_after_ack", 32'(sccb_req), 32'd0);
        case (cur.outcome)
          1: begin
            chk("done_set", 32'(init_done), 32'd1);
            chk("busy_clear_done", 32'(busy), 32'd0);
            run_end = 1'b1;
          end
          2: begin
            chk("err_set", 32'(init_err), 32'd1);
            chk("busy_clear_err", 32'(busy), 32'd0);
            chk("done_clear_err", 32'(init_done), 32'd0);
            run_end = 1'b1;
          end
          default: chk("busy_mid_run", 32'(busy), 32'd1);
        endcase
      end
      if (sccb_req && !req_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_request", 32'(sccb_reg_addr), 32'hffff_ffff);
        end else begin
          cur = exp_q.pop_front();
          chk("req_reg_addr", 32'(sccb_reg_addr), 32'(cur.addr));
          chk("req_wr_data", 32'(sccb_wr_data), 32'(cur.data));
          chk("req_gap", 32'(cyc - last_ref), 32'(cur.gap));
          chk("rom_addr_idx", 32'(rom_addr), 32'(cur.idx));
          in_write = 1'b1;
          hold = cur.hold;
        end
      end else if (in_write) begin
        chk("hold_req", 32'(sccb_req), 32'd1);
        chk("hold_reg_addr", 32'(sccb_reg_addr), 32'(cur.addr));
        chk("hold_wr_data", 32'(sccb_wr_data), 32'(cur.data));
      end
      if (in_write) begin
        if (hold == 0) begin
          sccb_ack = 1'b1;
          sccb_err = cur.err;
          last_ref = cyc + 1;
          in_write = 1'b0;
          post_ack = 1'b1;
        end else begin
          hold--;
        end
      end else if (!sccb_req && $urandom_range(0, 3) == 0) begin
        sccb_ack = 1'b1;   // stray ack while no request is pending
      end
      req_prev = sccb_req;
    end
  end

  task automatic do_start();
    @(negedge clk);
    run_end  = 1'b0;
    mon_en   = 1'b1;
    start    = 1'b1;
    last_ref = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("done_cleared", 32'(init_done), 32'd0);
    chk("err_cleared", 32'(init_err), 32'd0);
    chk("rom_addr_start", 32'(rom_addr), 32'd0);
  endtask

  task automatic wait_end();
    for (int i = 0; i < 3000 && !run_end; i++) @(negedge clk);
    chk("run_completed", 32'(run_end), 32'd1);
    repeat (20) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(sccb_req), 32'd0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, "_reg_addr"}, 32'(sccb_reg_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(sccb_wr_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(init_done), 32'd0);
    chk({tag, "_err"}, 32'(init_err), 32'd0);
  endtask

  initial begin
    int errs[TLEN];
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed run: two NACKs on entry 2, long hold on entry 1, ignored start in PWR_WAIT
    errs = '{0, 0, 2, 0};
    build_run(errs, 1);
    do_start();
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rom_addr_in_wait", 32'(rom_addr), 32'd0);
    wait_end();

    // Randomised runs, restarting from DONE or ERROR
    for (int run = 0; run < 8; run++) begin
      for (int e = 0; e < TLEN; e++) errs[e] = int'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) errs[$urandom_range(0, TLEN - 1)] = 4;
      build_run(errs, -1);
      do_start();
      wait_end();
    end

    // Retries exhausted on entry 2
    errs = '{0, 0, 4, 0};
    build_run(errs, -1);
    do_start();
    wait_end();
    chk("err_sticky", 32'(init_err), 32'd1);

    // Reset in the middle of a write
    errs = '{0, 0, 0, 0};
    build_run(errs, -1);
    do_start();
    for (int i = 0; i < 200 && !sccb_req; i++) @(negedge clk);
    chk("req_before_reset", 32'(sccb_req), 32'd1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    build_run(errs, -1);
    do_start();
    wait_end();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
